rtc_bus_responder: RTL and testbench
====================================

// Module: rtc_bus_responder
// PURPOSE
//  Synthesizable RTC-side responder for the multiplexed a_d/cs/rd/wr/dato bus driven by the RTC controller.
//  Latches addresses, serves BCD register reads/writes, runs a 1 s time/date chain and a countdown timer with an alarm.
//  Used as on-FPGA RTC emulation and as the bus-accurate slave in controller testbenches.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per 1 s tick; benches use 4
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-low reset
//  a_d       in   1  0 = address phase, 1 = data phase
//  cs        in   1  chip select, active low
//  rd        in   1  read strobe, active low
//  wr        in   1  write strobe, active low
//  dato_in   in   8  bus value from master
//  dato_out  out  8  bus value to master, valid while dato_oe=1
//  dato_oe   out  1  drive enable; top level builds the inout as dato = dato_oe ? dato_out : 8'hzz
//  irq       out  1  timer-done alarm, equal to ctrl[1]
// BEHAVIOUR
//  Reset: addr=00, ctrl=00, time 00:00:00, date 01-01-00, weekday 01, timer 00:00:00, dato_out=00, dato_oe=0, irq=0, tick divider=0.
//  Register map (BCD): 00 ctrl, 21 sec, 22 min, 23 hour (00-23), 24 day, 25 month, 26 year, 27 weekday (01-07),
//  41 timer sec, 42 timer min, 43 timer hour. ctrl bit0 = timer_en, bit1 = timer_done; bits 7:2 read 0.
//  Bus inputs are sampled every clk into *_q flops; each strobe edge is detected on the sampled value.
//  Write commit: one clk after the sampled wr rises (0->1) while the sampled cs was 0. a_d=0: addr<=dato_in; a_d=1: register[addr]<=dato_in.
//  ctrl write: bit0<=dato_in[0]; bit1 cleared if dato_in[1]=0, unchanged if 1.
//  Writes to unmapped addresses are ignored. Written values are stored as given, with no BCD validation.
//  Read: dato_oe<=1 and dato_out<=(a_d ? register[addr] : addr) on the first clk edge at which the sampled cs=0 and rd=0.
//  This read path updates every clk while cs=0 and rd=0. dato_oe<=0 on the first clk with the sampled rd=1 or cs=1.
//  Unmapped addresses read 00.
//  Tick: the divider counts 0..TICK_DIV-1 and emits a 1-clk tick at wrap. A tick applies only while the sampled cs=1.
//  A tick arriving while cs=0 sets tick_pend. tick_pend saturates at 1, so extra ticks are dropped. It is applied on the first clk with cs=1, then cleared.
//  Time chain: sec 59->00 carries to min, min 59->00 carries to hour, hour 23->00 carries to day and weekday.
//  Weekday 07->01. Day rolls to 01 past the month length and carries to month; month 12->01 carries to year; year 99->00.
//  Month lengths: 31/30 standard. Feb is 29 when the BCD year is divisible by 4 (tens even and units in {0,4,8}, or tens odd and units in {2,6}), else 28.
//  Timer: on an applied tick with timer_en=1 and timer!=00:00:00, decrement BCD HH:MM:SS with borrow (00 -> 59 for sec/min).
//  Reaching 00:00:00 sets timer_done and clears timer_en in the same clk. A timer at 00:00:00 with enable set does nothing.
//  Collision rule: if a write commit and an applied tick fall in the same clk, the written register takes the written value.
//  The remaining registers advance normally; a carry into the written register is discarded.
//  Reset mid-cycle: all state returns to reset values immediately. dato_oe drops asynchronously. The pending bus cycle is lost.
// STRUCTURE
//  Package rtc_bus_pkg: 8-bit address localparams (RTC_ADDR_*), ctrl bit indices, a bcd_inc/bcd_dec function pair, and a days_in_month(month, year) function.
//  One sub-module: rtc_calendar_chain. It takes the time/date registers, tick_apply and write overrides, and returns next-state values.
//  The responder keeps the bus FSM (IDLE, ADDR_WR, DATA_WR, READ), the divider, the timer and the register file.
// TESTING
//  Reset, then read 00/21/27 -> 00, 00, 01; dato_oe=0 when idle; irq=0.
//  Address write 23, data write 15, read back -> 15. Address write 7F, read -> 00. Read with a_d=0 -> dato_out=7F.
//  Set 23:59:59, 31-12-99, weekday 07; one tick -> 00:00:00, 01-01-00, weekday 01.
//  Set 28-02-24 23:59:59, tick -> 29-02; repeat with year 23 -> 01-03.
//  Timer 00:00:02, ctrl=01; two ticks -> timer 00:00:00, ctrl=02, irq=1. Write ctrl=00 -> irq=0.
//  Hold cs=0 across three tick periods, then release -> sec increments by exactly 1, one clk after cs=1.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus responder: register map, bus FSM states,
// register-file structs and BCD calendar helpers.
package rtc_bus_pkg;

  localparam logic [7:0] RTC_ADDR_CTRL  = 8'h00;
  localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
  localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;
  localparam logic [7:0] RTC_ADDR_WDAY  = 8'h27;
  localparam logic [7:0] RTC_ADDR_TSEC  = 8'h41;
  localparam logic [7:0] RTC_ADDR_TMIN  = 8'h42;
  localparam logic [7:0] RTC_ADDR_THOUR = 8'h43;

  localparam int CTRL_TIMER_EN   = 0;
  localparam int CTRL_TIMER_DONE = 1;

  typedef enum logic [1:0] {BUS_IDLE, BUS_ADDR_WR, BUS_DATA_WR, BUS_READ} bus_state_e;

  typedef struct packed {
    logic [7:0] sec, min, hour, day, month, year, wday;
  } rtc_time_t;

  typedef struct packed {
    logic [7:0] sec, min, hour;
  } rtc_timer_t;

  localparam rtc_time_t RTC_TIME_RST = '{sec: 8'h00, min: 8'h00, hour: 8'h00,
                                         day: 8'h01, month: 8'h01, year: 8'h00, wday: 8'h01};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return v - 8'h01;
  endfunction

  // BCD year divisible by 4: even tens with units 0/4/8, odd tens with units 2/6.
  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
    logic leap;
    leap = (!year[4] && (year[3:0] == 4'h0 || year[3:0] == 4'h4 || year[3:0] == 4'h8)) ||
           ( year[4] && (year[3:0] == 4'h2 || year[3:0] == 4'h6));
    case (month)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_calendar_chain.sv
// Next-state logic for the time/date chain: one applied tick ripples carries
// from seconds up to year; a same-clk bus write overrides its target register.
module rtc_calendar_chain import rtc_bus_pkg::*; (
  input  logic       tick_apply,
  input  rtc_time_t  cur,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output rtc_time_t  nxt
);

  logic c_sec, c_min, c_hour, c_day, c_mon;

  always_comb begin
    c_sec  = tick_apply && (cur.sec  == 8'h59);
    c_min  = c_sec      && (cur.min  == 8'h59);
    c_hour = c_min      && (cur.hour == 8'h23);
    c_day  = c_hour     && (cur.day  == days_in_month(cur.month, cur.year));
    c_mon  = c_day      && (cur.month == 8'h12);

    nxt = cur;
    if (tick_apply) nxt.sec   = c_sec  ? 8'h00 : bcd_inc(cur.sec);
    if (c_sec)      nxt.min   = c_min  ? 8'h00 : bcd_inc(cur.min);
    if (c_min)      nxt.hour  = c_hour ? 8'h00 : bcd_inc(cur.hour);
    if (c_hour) begin
      nxt.day  = c_day ? 8'h01 : bcd_inc(cur.day);
      nxt.wday = (cur.wday == 8'h07) ? 8'h01 : bcd_inc(cur.wday);
    end
    if (c_day)      nxt.month = c_mon ? 8'h01 : bcd_inc(cur.month);
    if (c_mon)      nxt.year  = (cur.year == 8'h99) ? 8'h00 : bcd_inc(cur.year);

    // Written register wins; carries into it are simply overwritten.
    if (wr_en) begin
      case (wr_addr)
        RTC_ADDR_SEC:   nxt.sec   = wr_data;
        RTC_ADDR_MIN:   nxt.min   = wr_data;
        RTC_ADDR_HOUR:  nxt.hour  = wr_data;
        RTC_ADDR_DAY:   nxt.day   = wr_data;
        RTC_ADDR_MONTH: nxt.month = wr_data;
        RTC_ADDR_YEAR:  nxt.year  = wr_data;
        RTC_ADDR_WDAY:  nxt.wday  = wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC-side bus slave: samples the multiplexed a_d/cs/rd/wr bus, serves BCD
// register reads/writes, and runs the 1 s calendar and countdown timer.
module rtc_bus_responder import rtc_bus_pkg::*; #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_d,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] dato_in,
  output logic [7:0] dato_out,
  output logic       dato_oe,
  output logic       irq
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic       a_d_q, cs_q, rd_q, wr_q;
  logic [7:0] din_q, wr_dat, addr_q, rdata;
  bus_state_e state_q, state_n;
  logic       commit_addr, commit_data, rd_active;
  logic [CW-1:0] div_q;
  logic       tick_raw, tick_pend_q, tick_apply;
  rtc_time_t  tm_q, tm_n;
  rtc_timer_t tmr_q, tmr_n;
  logic       en_q, done_q, en_n, done_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_d_q <= 1'b0; cs_q <= 1'b1; rd_q <= 1'b1; wr_q <= 1'b1;
      din_q <= 8'h00; wr_dat <= 8'h00;
    end else begin
      a_d_q <= a_d; cs_q <= cs; rd_q <= rd; wr_q <= wr;
      din_q <= dato_in;
      if (!wr_q) wr_dat <= din_q;   // last value seen while the strobe was low
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BUS_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      BUS_IDLE:
        if (!cs_q && !rd_q)      state_n = BUS_READ;
        else if (!cs_q && !wr_q) state_n = a_d_q ? BUS_DATA_WR : BUS_ADDR_WR;
      BUS_ADDR_WR, BUS_DATA_WR:
        if (wr_q || cs_q)        state_n = BUS_IDLE;
      BUS_READ:
        if (rd_q || cs_q)        state_n = BUS_IDLE;
      default:                   state_n = BUS_IDLE;
    endcase
  end

  always_comb begin
    commit_addr = (state_q == BUS_ADDR_WR) && wr_q;
    commit_data = (state_q == BUS_DATA_WR) && wr_q;
    rd_active   = (state_n == BUS_READ);
  end

  // Ticks landing mid-transaction are held (saturating) until cs goes idle.
  always_comb begin
    tick_raw   = (div_q == CW'(TICK_DIV - 1));
    tick_apply = cs_q && (tick_raw || tick_pend_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      div_q       <= tick_raw ? '0 : div_q + CW'(1);
      tick_pend_q <= cs_q ? 1'b0 : (tick_pend_q || tick_raw);
    end
  end

  rtc_calendar_chain u_chain (
    .tick_apply (tick_apply),
    .cur        (tm_q),
    .wr_en      (commit_data),
    .wr_addr    (addr_q),
    .wr_data    (wr_dat),
    .nxt        (tm_n)
  );

  always_comb begin
    tmr_n  = tmr_q;
    en_n   = en_q;
    done_n = done_q;
    if (tick_apply && en_q && (tmr_q != '0)) begin
      if (tmr_q.sec != 8'h00) tmr_n.sec = bcd_dec(tmr_q.sec);
      else begin
        tmr_n.sec = 8'h59;
        if (tmr_q.min != 8'h00) tmr_n.min = bcd_dec(tmr_q.min);
        else begin
          tmr_n.min  = 8'h59;
          tmr_n.hour = bcd_dec(tmr_q.hour);
        end
      end
      if (tmr_n == '0) begin
        done_n = 1'b1;
        en_n   = 1'b0;
      end
    end
    if (commit_data) begin
      case (addr_q)
        RTC_ADDR_CTRL: begin
          en_n   = wr_dat[CTRL_TIMER_EN];
          done_n = done_n && wr_dat[CTRL_TIMER_DONE];  // writing 1 leaves done alone
        end
        RTC_ADDR_TSEC:  tmr_n.sec  = wr_dat;
        RTC_ADDR_TMIN:  tmr_n.min  = wr_dat;
        RTC_ADDR_THOUR: tmr_n.hour = wr_dat;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_q)
      RTC_ADDR_CTRL:  rdata = {6'b0, done_q, en_q};
      RTC_ADDR_SEC:   rdata = tm_q.sec;
      RTC_ADDR_MIN:   rdata = tm_q.min;
      RTC_ADDR_HOUR:  rdata = tm_q.hour;
      RTC_ADDR_DAY:   rdata = tm_q.day;
      RTC_ADDR_MONTH: rdata = tm_q.month;
      RTC_ADDR_YEAR:  rdata = tm_q.year;
      RTC_ADDR_WDAY:  rdata = tm_q.wday;
      RTC_ADDR_TSEC:  rdata = tmr_q.sec;
      RTC_ADDR_TMIN:  rdata = tmr_q.min;
      RTC_ADDR_THOUR: rdata = tmr_q.hour;
      default:        rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= 8'h00;
      tm_q     <= RTC_TIME_RST;
      tmr_q    <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      dato_out <= 8'h00;
      dato_oe  <= 1'b0;
    end else begin
      if (commit_addr) addr_q <= wr_dat;
      tm_q    <= tm_n;
      tmr_q   <= tmr_n;
      en_q    <= en_n;
      done_q  <= done_n;
      dato_oe <= rd_active;
      if (rd_active) dato_out <= a_d_q ? rdata : addr_q;
    end
  end

  assign irq = done_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: bus read/write, calendar rollover,
// leap-year February, countdown timer/irq and tick saturation under cs=0.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset, a_d, cs, rd, wr;
  logic [7:0] dato_in, dato_out, rv;
  logic       dato_oe, irq, oe_seen;
  int         checks = 0;
  int         errors = 0;

  rtc_bus_responder #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .dato_in(dato_in), .dato_out(dato_out), .dato_oe(dato_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic ad, input logic [7:0] v);
    @(negedge clk); a_d = ad; dato_in = v; wr = 1'b0;
    repeat (2) @(negedge clk); wr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
    bus_wr(1'b0, a);
    bus_wr(1'b1, v);
  endtask

  task automatic bus_rd(input logic ad, output logic [7:0] v);
    @(negedge clk); a_d = ad; rd = 1'b0;
    repeat (2) @(negedge clk); v = dato_out; oe_seen = dato_oe;
    rd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    bus_wr(1'b0, a);
    bus_rd(1'b1, v);
  endtask

  // cs idles high for exactly one sampled clk after at least one full tick period low.
  task automatic pulse_cs;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    @(negedge clk); cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; a_d = 1'b0; cs = 1'b0; rd = 1'b1; wr = 1'b1; dato_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_oe", {7'b0, dato_oe}, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_dout", dato_out, 8'h00);
    reset = 1'b1;

    bus_rd(1'b1, rv);       check("rd_ctrl", rv, 8'h00);
    check("rd_oe_active", {7'b0, oe_seen}, 8'h01);
    check("idle_oe", {7'b0, dato_oe}, 8'h00);
    rd_reg(8'h21, rv);      check("rd_sec_rst", rv, 8'h00);
    rd_reg(8'h27, rv);      check("rd_wday_rst", rv, 8'h01);
    check("irq_idle", {7'b0, irq}, 8'h00);

    wr_reg(8'h23, 8'h15);
    bus_rd(1'b1, rv);       check("hour_wr_rd", rv, 8'h15);
    bus_wr(1'b0, 8'h7F);
    bus_rd(1'b1, rv);       check("unmapped_rd", rv, 8'h00);
    bus_rd(1'b0, rv);       check("addr_rd", rv, 8'h7F);

    wr_reg(8'h21, 8'h59); wr_reg(8'h22, 8'h59); wr_reg(8'h23, 8'h23);
    wr_reg(8'h24, 8'h31); wr_reg(8'h25, 8'h12); wr_reg(8'h26, 8'h99);
    wr_reg(8'h27, 8'h07);
    pulse_cs;
    rd_reg(8'h21, rv); check("roll_sec", rv, 8'h00);
    rd_reg(8'h22, rv); check("roll_min", rv, 8'h00);
    rd_reg(8'h23, rv); check("roll_hour", rv, 8'h00);
    rd_reg(8'h24, rv); check("roll_day", rv, 8'h01);
    rd_reg(8'h25, rv); check("roll_month", rv, 8'h01);
    rd_reg(8'h26, rv); check("roll_year", rv, 8'h00);
    rd_reg(8'h27, rv); check("roll_wday", rv, 8'h01);

    wr_reg(8'h21, 8'h59); wr_reg(8'h22, 8'h59); wr_reg(8'h23, 8'h23);
    wr_reg(8'h24, 8'h28); wr_reg(8'h25, 8'h02); wr_reg(8'h26, 8'h24);
    pulse_cs;
    rd_reg(8'h24, rv); check("leap_day", rv, 8'h29);
    rd_reg(8'h25, rv); check("leap_month", rv, 8'h02);

    wr_reg(8'h21, 8'h59); wr_reg(8'h22, 8'h59); wr_reg(8'h23, 8'h23);
    wr_reg(8'h24, 8'h28); wr_reg(8'h25, 8'h02); wr_reg(8'h26, 8'h23);
    pulse_cs;
    rd_reg(8'h24, rv); check("nonleap_day", rv, 8'h01);
    rd_reg(8'h25, rv); check("nonleap_month", rv, 8'h03);

    wr_reg(8'h41, 8'h02); wr_reg(8'h42, 8'h00); wr_reg(8'h43, 8'h00);
    wr_reg(8'h00, 8'h01);
    bus_rd(1'b1, rv);  check("ctrl_en", rv, 8'h01);
    pulse_cs;
    rd_reg(8'h41, rv); check("tmr_sec_1", rv, 8'h01);
    check("irq_running", {7'b0, irq}, 8'h00);
    pulse_cs;
    rd_reg(8'h41, rv); check("tmr_sec_0", rv, 8'h00);
    rd_reg(8'h00, rv); check("ctrl_done", rv, 8'h02);
    check("irq_set", {7'b0, irq}, 8'h01);
    wr_reg(8'h00, 8'h00);
    check("irq_clr", {7'b0, irq}, 8'h00);
    bus_rd(1'b1, rv);  check("ctrl_clr", rv, 8'h00);

    wr_reg(8'h21, 8'h10);
    repeat (14) @(negedge clk);
    pulse_cs;
    rd_reg(8'h21, rv); check("tick_saturate", rv, 8'h11);

    @(negedge clk); a_d = 1'b1; rd = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rd_oe", {7'b0, dato_oe}, 8'h01);
    #2 reset = 1'b0;
    #1 check("async_rst_oe", {7'b0, dato_oe}, 8'h00);
    rd = 1'b1;
    @(negedge clk); reset = 1'b1;
    bus_rd(1'b0, rv);  check("rst_addr", rv, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
